// File: rtl/channel_combinator_core.sv
`timescale 1ns/1ps
// Merges high-gain ch1 and gain/offset-corrected low-gain ch2 into one stream; output registered, latency 1 clk.
// No backpressure: state advances on enable_3M. Optional calibration under `COMB_CALIB_EN.
module channel_combinator_core #(
  parameter int DATA_W    = 11,
  parameter int WIN_LOG2  = 6,
  parameter int GAIN_FRAC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_3M,
  input  logic              select,
  input  logic [DATA_W-1:0] data_c1,
  input  logic [DATA_W-1:0] data_c2,
  output logic [DATA_W-1:0] data_output
);

  localparam int GAIN_W = GAIN_FRAC + 2;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [GAIN_W-1:0]        GAIN_ONE = GAIN_W'(1) << GAIN_FRAC;

  logic        [GAIN_W-1:0] w_gain;
  logic signed [DATA_W-1:0] w_offset;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_corr;
  logic        [DATA_W-1:0] r_out;

  function automatic logic [DATA_W-1:0] f_sat(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  assign w_prod = $signed(data_c2) * $signed({1'b0, w_gain});
  assign w_corr = (w_prod >>> GAIN_FRAC) + PROD_W'(w_offset);

  always_ff @(posedge clk) begin
    if (reset)          r_out <= '0;
    else if (enable_3M) r_out <= select ? f_sat(w_corr) : data_c1;
  end
  assign data_output = r_out;

`ifdef COMB_CALIB_EN
  localparam int ACC_W  = DATA_W + WIN_LOG2;
  localparam int STEP_W = $clog2(GAIN_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(GAIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPD} state_t;
  state_t r_state;

  logic        [GAIN_W-1:0]   r_gain, r_quo, r_dlo;
  logic signed [DATA_W-1:0]   r_offset, r_m1, r_m2;
  logic signed [ACC_W-1:0]    r_s1, r_s2;
  logic        [ACC_W-1:0]    r_a1, r_a2, r_div, r_rem;
  logic        [WIN_LOG2-1:0] r_cnt;
  logic        [STEP_W-1:0]   r_step;
  logic                       r_ovf;

  logic        [DATA_W-1:0]          w_abs1, w_abs2;
  logic signed [ACC_W-1:0]           w_s1n, w_s2n;
  logic        [ACC_W-1:0]           w_a1n, w_a2n, w_dvd_hi, w_diff;
  logic        [ACC_W+GAIN_FRAC-1:0] w_dvd;
  logic        [ACC_W:0]             w_trial;
  logic                              w_ge;
  logic        [GAIN_W-1:0]          w_gnew;
  logic signed [PROD_W-1:0]          w_mprod, w_off_full;

  // -(-2^(DATA_W-1)) wraps to 2^(DATA_W-1), which is still correct read as unsigned
  assign w_abs1 = data_c1[DATA_W-1] ? (~data_c1) + DATA_W'(1) : data_c1;
  assign w_abs2 = data_c2[DATA_W-1] ? (~data_c2) + DATA_W'(1) : data_c2;
  assign w_s1n  = r_s1 + ACC_W'($signed(data_c1));
  assign w_s2n  = r_s2 + ACC_W'($signed(data_c2));
  assign w_a1n  = r_a1 + ACC_W'(w_abs1);
  assign w_a2n  = r_a2 + ACC_W'(w_abs2);

  // Only GAIN_W quotient bits are produced; a high part >= divisor means g >= 4.0
  assign w_dvd    = {w_a1n, {GAIN_FRAC{1'b0}}};
  assign w_dvd_hi = ACC_W'(w_dvd[ACC_W+GAIN_FRAC-1:GAIN_W]);
  assign w_trial  = {r_rem, r_dlo[GAIN_W-1]};
  assign w_ge     = w_trial >= {1'b0, r_div};
  assign w_diff   = w_ge ? ACC_W'(w_trial - {1'b0, r_div}) : w_trial[ACC_W-1:0];

  assign w_gnew     = r_ovf ? '1 : r_quo;
  assign w_mprod    = r_m2 * $signed({1'b0, w_gnew});
  assign w_off_full = PROD_W'(r_m1) - (w_mprod >>> GAIN_FRAC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gain <= GAIN_ONE;   r_offset <= '0;
      r_s1 <= '0; r_s2 <= '0; r_a1 <= '0; r_a2 <= '0; r_cnt <= '0;
      r_m1 <= '0; r_m2 <= '0; r_div <= '0; r_rem <= '0;
      r_dlo <= '0; r_quo <= '0; r_step <= '0; r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_DIV: begin
          r_rem  <= w_diff;
          r_dlo  <= r_dlo << 1;
          r_quo  <= {r_quo[GAIN_W-2:0], w_ge};
          r_step <= r_step + STEP_W'(1);
          if (r_step == LAST_STEP) r_state <= S_UPD;
        end
        S_UPD: begin
          r_gain   <= w_gnew;
          r_offset <= f_sat(w_off_full);
          r_state  <= S_IDLE;
        end
        S_IDLE:  ;
        default: r_state <= S_IDLE;
      endcase
      if (enable_3M) begin
        r_cnt <= r_cnt + WIN_LOG2'(1);
        if (r_cnt == '1) begin
          r_s1 <= '0; r_s2 <= '0; r_a1 <= '0; r_a2 <= '0;
          // An all-zero ch2 window gives no ratio: skip the division and keep the old values
          if (w_a2n != '0) begin
            r_m1    <= w_s1n[ACC_W-1:WIN_LOG2];
            r_m2    <= w_s2n[ACC_W-1:WIN_LOG2];
            r_div   <= w_a2n;
            r_rem   <= w_dvd_hi;
            r_dlo   <= w_dvd[GAIN_W-1:0];
            r_ovf   <= w_dvd_hi >= w_a2n;
            r_quo   <= '0;
            r_step  <= '0;
            r_state <= S_DIV;
          end
        end else begin
          r_s1 <= w_s1n; r_s2 <= w_s2n; r_a1 <= w_a1n; r_a2 <= w_a2n;
        end
      end
    end
  end

  assign w_gain   = r_gain;
  assign w_offset = r_offset;
`else
  assign w_gain   = GAIN_ONE;
  assign w_offset = '0;
`endif

endmodule

// File: tb/tb_channel_combinator_core.sv
`timescale 1ns/1ps
// Directed bench for channel_combinator_core with a scoreboard queue and a behavioural gain/offset model.
module tb_channel_combinator_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_3M = 1'b0;
  logic        select = 1'b0;
  logic [10:0] data_c1 = '0;
  logic [10:0] data_c2 = '0;
  logic [10:0] data_output;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] exp_q[$];
  logic [10:0] last_exp = '0;

  // reference model state
  longint m_gain = 1024, m_off = 0;
  longint m_s1 = 0, m_s2 = 0, m_a1 = 0, m_a2 = 0;
  int     m_cnt = 0;
  int     p_cd = 0;
  longint p_gain = 0, p_off = 0;

  channel_combinator_core dut (
    .clk         (clk),
    .reset       (reset),
    .enable_3M   (enable_3M),
    .select      (select),
    .data_c1     (data_c1),
    .data_c2     (data_c2),
    .data_output (data_output)
  );

  always #20 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint sat11(input longint v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    n_tests++;
    assert (data_output === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(data_output), $signed(exp));
    end
  endtask

  task automatic model_clear();
    m_gain = 1024; m_off = 0;
    m_s1 = 0; m_s2 = 0; m_a1 = 0; m_a2 = 0; m_cnt = 0;
    p_cd = 0;
    exp_q.delete();
    last_exp = '0;
  endtask

  task automatic model_step(input int c1, input int c2, input bit sel);
    longint e, g, off;
    // a window's result first applies two strobes after the window closes
    if (p_cd > 0) begin
      p_cd--;
      if (p_cd == 0) begin m_gain = p_gain; m_off = p_off; end
    end
    e = sel ? sat11(((longint'(c2) * m_gain) >>> 10) + m_off) : longint'(c1);
    exp_q.push_back(11'(e));
`ifdef COMB_CALIB_EN
    m_s1 += c1; m_s2 += c2;
    m_a1 += (c1 < 0) ? -c1 : c1;
    m_a2 += (c2 < 0) ? -c2 : c2;
    m_cnt++;
    if (m_cnt == 64) begin
      if (m_a2 != 0) begin
        g = (m_a1 * 1024) / m_a2;
        if (g > 4095) g = 4095;
        off = sat11((m_s1 >>> 6) - (((m_s2 >>> 6) * g) >>> 10));
        p_gain = g; p_off = off; p_cd = 2;
      end
      m_s1 = 0; m_s2 = 0; m_a1 = 0; m_a2 = 0; m_cnt = 0;
    end
`endif
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b1;
    enable_3M = 1'b1;
    select = 1'b0;
    data_c1 = 11'd100;
    data_c2 = 11'd50;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      check("reset", 11'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    enable_3M = 1'b0;
    model_clear();
  endtask

  task automatic strobe(input int c1, input int c2, input bit sel, input string tag);
    logic [10:0] e;
    @(negedge clk);
    data_c1 = 11'(c1);
    data_c2 = 11'(c2);
    select = sel;
    enable_3M = 1'b1;
    model_step(c1, c2, sel);
    @(posedge clk); #1;
    enable_3M = 1'b0;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0d", tag, $signed(data_output));
    end else begin
      e = exp_q.pop_front();
      check(tag, e);
      last_exp = e;
    end
    // scramble inputs between strobes; the output must not move
    data_c1 = 11'($urandom);
    data_c2 = 11'($urandom);
    select  = 1'($urandom);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_hold"}, last_exp);
  endtask

  initial begin
    do_reset(3);
    strobe(100, 50, 1'b0, "t1_first");
    strobe(100, 50, 1'b1, "t1_sel1");
    strobe(-1024, 1023, 1'b1, "t1_max");
    strobe(1023, -1024, 1'b0, "t1_min");

    // discard the partial window
    do_reset(1);

    for (int i = 0; i < 64; i++) strobe(200, 100, 1'(i % 2), "t3_win");
    strobe(200, 100, 1'b1, "t3_pend");
    strobe(200, 100, 1'b1, "t3_gain2");

    strobe(0, 1000, 1'b1, "t5_satp");
    strobe(0, -1000, 1'b1, "t5_satn");
    strobe(0, 1023, 1'b1, "t5_max");
    strobe(0, -1024, 1'b1, "t5_min");
    strobe(-1024, 5, 1'b0, "t5_c1min");
    for (int i = 0; i < 57; i++)
      strobe(-150 + (i % 7) * 10, -70 + (i % 5) * 3, 1'(i % 3 == 0), "t_neg_win");

    for (int i = 0; i < 64; i++) strobe(37 + i, 0, 1'b1, "t4_zero_c2");

    for (int i = 0; i < 64; i++) strobe(900, 100, 1'(i % 4 != 0), "t_clamp_win");
    strobe(900, 100, 1'b1, "t_clamp_pend");
    strobe(900, 100, 1'b1, "t_clamp");
    strobe(0, -100, 1'b1, "t_clamp_neg");

    strobe(-5, 7, 1'b1, "t6_pre");
    do_reset(2);
    strobe(-5, 7, 1'b1, "t6_sel1");
    strobe(-5, 7, 1'b0, "t6_sel0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
